// File: rtl/unidade_pc_if.sv
// -----------------------------------------------------------------------------
// unidade_pc_if
//   Bus between the control unit / ALU and the program-counter unit.
//   Clock and reset stay outside the bundle as plain ports of the unit.
//
//   master : control side (drives mode, flag and targets; reads PC and status)
//   slave  : program-counter unit
//
//   habilita        PC write enable (0 = stall)
//   sel             next-address mode code
//   zero            ALU zero flag for conditional branches
//   endJump         absolute jump / call target
//   endDesvio       branch target
//   endRegistrador  register-sourced target (jr, empty-return fallback)
//   pc              current PC (registered)
//   pc_mais4        pc + increment (combinational)
//   desvio_tomado   next address is not the sequential one
//   pilha_vazia     return stack empty (registered)
//   pilha_cheia     return stack full (registered)
//   erro_pilha      sticky stack overflow / underflow
// -----------------------------------------------------------------------------
interface unidade_pc_if #(
  parameter int LARGURA = 32
);

  logic               habilita;
  logic [2:0]         sel;
  logic               zero;
  logic [LARGURA-1:0] endJump;
  logic [LARGURA-1:0] endDesvio;
  logic [LARGURA-1:0] endRegistrador;
  logic [LARGURA-1:0] pc;
  logic [LARGURA-1:0] pc_mais4;
  logic               desvio_tomado;
  logic               pilha_vazia;
  logic               pilha_cheia;
  logic               erro_pilha;

  modport master (
    output habilita, sel, zero, endJump, endDesvio, endRegistrador,
    input  pc, pc_mais4, desvio_tomado, pilha_vazia, pilha_cheia, erro_pilha
  );

  modport slave (
    input  habilita, sel, zero, endJump, endDesvio, endRegistrador,
    output pc, pc_mais4, desvio_tomado, pilha_vazia, pilha_cheia, erro_pilha
  );

endinterface

// File: rtl/unidade_pc.sv
// -----------------------------------------------------------------------------
// unidade_pc
//   Registered program-counter unit. Holds the PC, selects the next fetch
//   address from a 3-bit mode code and updates it on every enabled rising
//   edge. Calls and returns go through a circular return-address stack whose
//   top pointer always addresses the most recent entry.
//
//   Ports
//     clock   system clock, all state changes on its rising edge
//     reset   synchronous, active-high; overrides habilita
//     bus     unidade_pc_if.slave (see the interface header for signals)
//
//   Parameters
//     LARGURA         address width in bits (>= 8)
//     ENDERECO_RESET  PC value loaded on reset
//     INCREMENTO      sequential step
//     PROF_PILHA      return stack depth (power of two, >= 2)
// -----------------------------------------------------------------------------
module unidade_pc #(
  parameter int                 LARGURA        = 32,
  parameter logic [LARGURA-1:0] ENDERECO_RESET = '0,
  parameter int                 INCREMENTO     = 4,
  parameter int                 PROF_PILHA     = 4
) (
  input logic           clock,
  input logic           reset,
  unidade_pc_if.slave   bus
);

  localparam int PW = (PROF_PILHA > 1) ? $clog2(PROF_PILHA) : 1;

  localparam logic [LARGURA-1:0] PASSO   = LARGURA'(INCREMENTO);
  localparam logic [PW-1:0]      UM_TOPO = PW'(1);
  localparam logic [PW:0]        UM_OCUP = (PW + 1)'(1);
  localparam logic [PW:0]        CHEIO   = (PW + 1)'(PROF_PILHA);

  typedef enum logic [2:0] {
    MODO_SEQ  = 3'b000,
    MODO_JUMP = 3'b001,
    MODO_BEQ  = 3'b010,
    MODO_BNE  = 3'b011,
    MODO_CALL = 3'b100,
    MODO_RET  = 3'b101,
    MODO_JR   = 3'b110,
    MODO_RSV  = 3'b111
  } modo_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LARGURA-1:0] pc_q,    pc_d;
  logic [PW-1:0]      topo_q,  topo_d;
  logic [PW:0]        ocup_q,  ocup_d;
  logic               erro_q,  erro_d;
  logic               vazia_q, vazia_d;
  logic               cheia_q, cheia_d;
  logic [LARGURA-1:0] pilha_q [PROF_PILHA];
  logic [LARGURA-1:0] pilha_d [PROF_PILHA];

  // ---------------------------------------------------------------------------
  // Combinational next-address selection
  // ---------------------------------------------------------------------------
  modo_e              modo;
  logic [LARGURA-1:0] pc_mais4;
  logic [LARGURA-1:0] proximo;
  logic               desvio_tomado;
  logic               empilha;
  logic               desempilha;
  logic               vazia_atual;
  logic               cheia_atual;
  logic [PW-1:0]      topo_mais1;

  assign modo        = modo_e'(bus.sel);
  // Wrap-around past 2^LARGURA is intentional and silent.
  assign pc_mais4    = pc_q + PASSO;
  assign vazia_atual = (ocup_q == '0);
  assign cheia_atual = (ocup_q == CHEIO);
  assign topo_mais1  = topo_q + UM_TOPO;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    proximo       = pc_mais4;
    desvio_tomado = 1'b0;
    empilha       = 1'b0;
    desempilha    = 1'b0;

    case (modo)
      MODO_SEQ: begin
        proximo = pc_mais4;
      end
      MODO_JUMP: begin
        proximo       = bus.endJump;
        desvio_tomado = 1'b1;
      end
      MODO_BEQ: begin
        if (bus.zero) begin
          proximo       = bus.endDesvio;
          desvio_tomado = 1'b1;
        end
      end
      MODO_BNE: begin
        if (!bus.zero) begin
          proximo       = bus.endDesvio;
          desvio_tomado = 1'b1;
        end
      end
      MODO_CALL: begin
        proximo       = bus.endJump;
        desvio_tomado = 1'b1;
        empilha       = 1'b1;
      end
      MODO_RET: begin
        desvio_tomado = 1'b1;
        desempilha    = 1'b1;
        // An empty stack falls back to the register target.
        proximo       = vazia_atual ? bus.endRegistrador : pilha_q[topo_q];
      end
      MODO_JR: begin
        proximo       = bus.endRegistrador;
        desvio_tomado = 1'b1;
      end
      default: begin
        // Reserved code: sequential, no stack action.
        proximo = pc_mais4;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state for PC and return stack; habilita=0 freezes everything.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    topo_d  = topo_q;
    ocup_d  = ocup_q;
    erro_d  = erro_q;
    pilha_d = pilha_q;

    if (bus.habilita) begin
      pc_d = proximo;

      if (empilha) begin
        // When full, topo+1 is the oldest slot, so it is overwritten.
        topo_d              = topo_mais1;
        pilha_d[topo_mais1] = pc_mais4;
        if (cheia_atual) begin
          erro_d = 1'b1;
        end else begin
          ocup_d = ocup_q + UM_OCUP;
        end
      end else if (desempilha) begin
        if (vazia_atual) begin
          erro_d = 1'b1;
        end else begin
          topo_d = topo_q - UM_TOPO;
          ocup_d = ocup_q - UM_OCUP;
        end
      end
    end

    vazia_d = (ocup_d == '0);
    cheia_d = (ocup_d == CHEIO);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      pc_q    <= ENDERECO_RESET;
      topo_q  <= '0;
      ocup_q  <= '0;
      erro_q  <= 1'b0;
      vazia_q <= 1'b1;
      cheia_q <= 1'b0;
      // NOTE: the stack is small and must read back as zero after reset, so
      // it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < PROF_PILHA; i++) begin
        pilha_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      topo_q  <= topo_d;
      ocup_q  <= ocup_d;
      erro_q  <= erro_d;
      vazia_q <= vazia_d;
      cheia_q <= cheia_d;
      for (int i = 0; i < PROF_PILHA; i++) begin
        pilha_q[i] <= pilha_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pc            = pc_q;
  assign bus.pc_mais4      = pc_mais4;
  assign bus.desvio_tomado = desvio_tomado;
  assign bus.pilha_vazia   = vazia_q;
  assign bus.pilha_cheia   = cheia_q;
  assign bus.erro_pilha    = erro_q;

endmodule

// File: tb/tb_unidade_pc.sv
// -----------------------------------------------------------------------------
// tb_unidade_pc
//   Directed bench for unidade_pc: a 32-bit instance (reset 0, step 4,
//   depth 4) for most scenarios and an 8-bit instance for address wrap.
// -----------------------------------------------------------------------------
module tb_unidade_pc;

  logic clock;
  logic reset;

  int n_checks;
  int n_fail;

  unidade_pc_if #(.LARGURA(32)) bus_a ();
  unidade_pc_if #(.LARGURA(8))  bus_b ();

  unidade_pc #(
    .LARGURA(32), .ENDERECO_RESET(32'h0), .INCREMENTO(4), .PROF_PILHA(4)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  unidade_pc #(
    .LARGURA(8), .ENDERECO_RESET(8'h0), .INCREMENTO(4), .PROF_PILHA(4)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic hab, input logic [2:0] s, input logic z,
                         input logic [31:0] jmp, input logic [31:0] dsv,
                         input logic [31:0] rg);
    bus_a.habilita       = hab;
    bus_a.sel            = s;
    bus_a.zero           = z;
    bus_a.endJump        = jmp;
    bus_a.endDesvio      = dsv;
    bus_a.endRegistrador = rg;
    #1;
  endtask

  task automatic drive_b(input logic hab, input logic [2:0] s,
                         input logic [7:0] jmp);
    bus_b.habilita       = hab;
    bus_b.sel            = s;
    bus_b.zero           = 1'b0;
    bus_b.endJump        = jmp;
    bus_b.endDesvio      = 8'h0;
    bus_b.endRegistrador = 8'h0;
    #1;
  endtask

  task automatic do_reset();
    drive_a(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0);
    drive_b(1'b0, 3'b000, 8'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] exp_pc;
    do_reset();
    n_checks++;
    if (bus_a.pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h want %h", bus_a.pc, 32'h0);
    end
    n_checks++;
    if (bus_a.pilha_vazia !== 1'b1 || bus_a.pilha_cheia !== 1'b0 || bus_a.erro_pilha !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got vazia=%b cheia=%b erro=%b want 1 0 0",
                         bus_a.pilha_vazia, bus_a.pilha_cheia, bus_a.erro_pilha);
    end
    drive_a(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0);
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus_a.desvio_tomado !== 1'b0) begin
        n_fail++; $display("FAIL seq_desvio[%0d]: got %b want 0", i, bus_a.desvio_tomado);
      end
      tick();
      exp_pc = exp_pc + 32'd4;
      n_checks++;
      if (bus_a.pc !== exp_pc || bus_a.pilha_vazia !== 1'b1) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got pc=%h vazia=%b want pc=%h vazia=1",
                           i, bus_a.pc, bus_a.pilha_vazia, exp_pc);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branches();
    do_reset();
    drive_a(1'b1, 3'b001, 1'b0, 32'h10, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h10) begin
      n_fail++; $display("FAIL jump_pc: got %h want %h", bus_a.pc, 32'h10);
    end
    // beq taken
    drive_a(1'b1, 3'b010, 1'b1, 32'h0, 32'h40, 32'h0);
    n_checks++;
    if (bus_a.desvio_tomado !== 1'b1) begin
      n_fail++; $display("FAIL beq_taken_desvio: got %b want 1", bus_a.desvio_tomado);
    end
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h40) begin
      n_fail++; $display("FAIL beq_taken_pc: got %h want %h", bus_a.pc, 32'h40);
    end
    // bne not taken
    drive_a(1'b1, 3'b011, 1'b1, 32'h0, 32'h40, 32'h0);
    n_checks++;
    if (bus_a.desvio_tomado !== 1'b0) begin
      n_fail++; $display("FAIL bne_not_desvio: got %b want 0", bus_a.desvio_tomado);
    end
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h44) begin
      n_fail++; $display("FAIL bne_not_pc: got %h want %h", bus_a.pc, 32'h44);
    end
    // bne taken
    drive_a(1'b1, 3'b011, 1'b0, 32'h0, 32'h80, 32'h0);
    n_checks++;
    if (bus_a.desvio_tomado !== 1'b1) begin
      n_fail++; $display("FAIL bne_taken_desvio: got %b want 1", bus_a.desvio_tomado);
    end
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h80) begin
      n_fail++; $display("FAIL bne_taken_pc: got %h want %h", bus_a.pc, 32'h80);
    end
    // beq not taken
    drive_a(1'b1, 3'b010, 1'b0, 32'h0, 32'h200, 32'h0);
    n_checks++;
    if (bus_a.desvio_tomado !== 1'b0) begin
      n_fail++; $display("FAIL beq_not_desvio: got %b want 0", bus_a.desvio_tomado);
    end
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h84) begin
      n_fail++; $display("FAIL beq_not_pc: got %h want %h", bus_a.pc, 32'h84);
    end
    // jr
    drive_a(1'b1, 3'b110, 1'b0, 32'h0, 32'h0, 32'h3C0);
    n_checks++;
    if (bus_a.desvio_tomado !== 1'b1) begin
      n_fail++; $display("FAIL jr_desvio: got %b want 1", bus_a.desvio_tomado);
    end
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h3C0) begin
      n_fail++; $display("FAIL jr_pc: got %h want %h", bus_a.pc, 32'h3C0);
    end
    // reserved code behaves as sequential
    drive_a(1'b1, 3'b111, 1'b1, 32'h500, 32'h600, 32'h700);
    n_checks++;
    if (bus_a.desvio_tomado !== 1'b0) begin
      n_fail++; $display("FAIL rsv_desvio: got %b want 0", bus_a.desvio_tomado);
    end
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h3C4 || bus_a.pilha_vazia !== 1'b1 || bus_a.erro_pilha !== 1'b0) begin
      n_fail++; $display("FAIL rsv_pc: got pc=%h vazia=%b erro=%b want pc=%h vazia=1 erro=0",
                         bus_a.pc, bus_a.pilha_vazia, bus_a.erro_pilha, 32'h3C4);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_call_return();
    do_reset();
    drive_a(1'b1, 3'b001, 1'b0, 32'h100, 32'h0, 32'h0);
    tick();
    drive_a(1'b1, 3'b100, 1'b0, 32'h200, 32'h0, 32'h0);
    n_checks++;
    if (bus_a.desvio_tomado !== 1'b1) begin
      n_fail++; $display("FAIL call_desvio: got %b want 1", bus_a.desvio_tomado);
    end
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h200 || bus_a.pilha_vazia !== 1'b0) begin
      n_fail++; $display("FAIL call_pc: got pc=%h vazia=%b want pc=%h vazia=0",
                         bus_a.pc, bus_a.pilha_vazia, 32'h200);
    end
    drive_a(1'b1, 3'b101, 1'b0, 32'h0, 32'h0, 32'hDEAD0);
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h104 || bus_a.pilha_vazia !== 1'b1 || bus_a.erro_pilha !== 1'b0) begin
      n_fail++; $display("FAIL ret_pc: got pc=%h vazia=%b erro=%b want pc=%h vazia=1 erro=0",
                         bus_a.pc, bus_a.pilha_vazia, bus_a.erro_pilha, 32'h104);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h44;
    exp_ret[1] = 32'h34;
    exp_ret[2] = 32'h24;
    exp_ret[3] = 32'h14;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        drive_a(1'b1, 3'b001, 1'b0, 32'(i * 16), 32'h0, 32'h0);
        tick();
      end
      drive_a(1'b1, 3'b100, 1'b0, 32'h1000, 32'h0, 32'h0);
      tick();
      if (i == 3) begin
        n_checks++;
        if (bus_a.pilha_cheia !== 1'b1 || bus_a.erro_pilha !== 1'b0) begin
          n_fail++; $display("FAIL fill4: got cheia=%b erro=%b want 1 0",
                             bus_a.pilha_cheia, bus_a.erro_pilha);
        end
      end
    end
    n_checks++;
    if (bus_a.pilha_cheia !== 1'b1 || bus_a.erro_pilha !== 1'b1 || bus_a.pc !== 32'h1000) begin
      n_fail++; $display("FAIL overflow: got cheia=%b erro=%b pc=%h want 1 1 %h",
                         bus_a.pilha_cheia, bus_a.erro_pilha, bus_a.pc, 32'h1000);
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 3'b101, 1'b0, 32'h0, 32'h0, 32'hBAD0);
      tick();
      n_checks++;
      if (bus_a.pc !== exp_ret[i] || bus_a.pilha_cheia !== 1'b0) begin
        n_fail++; $display("FAIL ovf_ret[%0d]: got pc=%h cheia=%b want pc=%h cheia=0",
                           i, bus_a.pc, bus_a.pilha_cheia, exp_ret[i]);
      end
    end
    n_checks++;
    if (bus_a.pilha_vazia !== 1'b1 || bus_a.erro_pilha !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drained: got vazia=%b erro=%b want 1 1",
                         bus_a.pilha_vazia, bus_a.erro_pilha);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_underflow_stall();
    do_reset();
    drive_a(1'b1, 3'b101, 1'b0, 32'h0, 32'h0, 32'h80);
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h80 || bus_a.erro_pilha !== 1'b1 || bus_a.pilha_vazia !== 1'b1) begin
      n_fail++; $display("FAIL underflow: got pc=%h erro=%b vazia=%b want %h 1 1",
                         bus_a.pc, bus_a.erro_pilha, bus_a.pilha_vazia, 32'h80);
    end
    drive_a(1'b0, 3'b001, 1'b0, 32'h999, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus_a.desvio_tomado !== 1'b1) begin
        n_fail++; $display("FAIL stall_desvio[%0d]: got %b want 1", i, bus_a.desvio_tomado);
      end
      tick();
      n_checks++;
      if (bus_a.pc !== 32'h80 || bus_a.erro_pilha !== 1'b1) begin
        n_fail++; $display("FAIL stall_pc[%0d]: got pc=%h erro=%b want %h 1",
                           i, bus_a.pc, bus_a.erro_pilha, 32'h80);
      end
    end
    // A call during stall must not push.
    drive_a(1'b0, 3'b100, 1'b0, 32'h777, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h80 || bus_a.pilha_vazia !== 1'b1) begin
      n_fail++; $display("FAIL stall_call: got pc=%h vazia=%b want %h 1",
                         bus_a.pc, bus_a.pilha_vazia, 32'h80);
    end
    drive_a(1'b1, 3'b001, 1'b0, 32'h999, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h999 || bus_a.erro_pilha !== 1'b1) begin
      n_fail++; $display("FAIL unstall: got pc=%h erro=%b want %h 1",
                         bus_a.pc, bus_a.erro_pilha, 32'h999);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    do_reset();
    drive_b(1'b1, 3'b001, 8'hFC);
    tick();
    n_checks++;
    if (bus_b.pc !== 8'hFC || bus_b.pc_mais4 !== 8'h00) begin
      n_fail++; $display("FAIL wrap_setup: got pc=%h pc_mais4=%h want fc 00",
                         bus_b.pc, bus_b.pc_mais4);
    end
    drive_b(1'b1, 3'b000, 8'h00);
    tick();
    n_checks++;
    if (bus_b.pc !== 8'h00) begin
      n_fail++; $display("FAIL wrap_pc: got %h want 00", bus_b.pc);
    end
    drive_b(1'b0, 3'b000, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_call();
    do_reset();
    drive_a(1'b1, 3'b101, 1'b0, 32'h0, 32'h0, 32'h20);
    tick();
    drive_a(1'b1, 3'b100, 1'b0, 32'h300, 32'h0, 32'h0);
    tick();
    drive_a(1'b1, 3'b100, 1'b0, 32'h400, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h400 || bus_a.pilha_vazia !== 1'b0 || bus_a.erro_pilha !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got pc=%h vazia=%b erro=%b want %h 0 1",
                         bus_a.pc, bus_a.pilha_vazia, bus_a.erro_pilha, 32'h400);
    end
    // Reset wins over an enabled jump presented in the same cycle.
    drive_a(1'b1, 3'b001, 1'b0, 32'h555, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus_a.pc !== 32'h0 || bus_a.pilha_vazia !== 1'b1 ||
        bus_a.pilha_cheia !== 1'b0 || bus_a.erro_pilha !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got pc=%h vazia=%b cheia=%b erro=%b want 0 1 0 0",
                         bus_a.pc, bus_a.pilha_vazia, bus_a.pilha_cheia, bus_a.erro_pilha);
    end
    // The stack really is empty: a return takes the register fallback.
    drive_a(1'b1, 3'b101, 1'b0, 32'h0, 32'h0, 32'h60);
    tick();
    n_checks++;
    if (bus_a.pc !== 32'h60 || bus_a.erro_pilha !== 1'b1) begin
      n_fail++; $display("FAIL mid_ret_empty: got pc=%h erro=%b want %h 1",
                         bus_a.pc, bus_a.erro_pilha, 32'h60);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive_a(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0);
    drive_b(1'b0, 3'b000, 8'h0);

    test_reset();
    test_branches();
    test_call_return();
    test_overflow();
    test_underflow_stall();
    test_wrap();
    test_reset_mid_call();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unidade_pc.md
Name: unidade_pc

Overview:
- Registered program-counter unit for the processor datapath: holds the PC, computes the next fetch address, and updates it on each enabled clock edge.
- The 3-bit selection code is fully decoded into sequential, jump, branch-if-zero, branch-if-not-zero, call, return and jump-register modes.
- Calls and returns use a parametrised circular return-address stack.
- Sits between the control unit/ALU (sel, zero, targets) and instruction memory (pc).

Parameters:
- LARGURA, 32, address width in bits (≥ 8).
- ENDERECO_RESET, 0, PC value loaded on reset.
- INCREMENTO, 4, sequential step added to pc.
- PROF_PILHA, 4, return-stack depth in entries (power of two, ≥ 2).

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- habilita  input  1  PC write enable; 0 = stall.
- sel  input  3  next-address mode code (see Behaviour).
- zero  input  1  ALU zero flag for conditional branches.
- endJump  input  LARGURA  absolute jump/call target.
- endDesvio  input  LARGURA  branch target.
- endRegistrador  input  LARGURA  register-sourced target (jr; fallback for an empty return).
- pc  output  LARGURA  current PC, registered.
- pc_mais4  output  LARGURA  pc + INCREMENTO, combinational.
- desvio_tomado  output  1  combinational; 1 when the next address is not pc_mais4 by mode.
- pilha_vazia  output  1  registered; return-stack occupancy = 0.
- pilha_cheia  output  1  registered; occupancy = PROF_PILHA.
- erro_pilha  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset, when reset=1 at a rising edge, overriding habilita:
  - pc <= ENDERECO_RESET.
  - Stack pointer and occupancy <= 0; all entries <= 0.
  - erro_pilha <= 0; pilha_vazia=1; pilha_cheia=0.
- Reset mid-stall or mid-call discards all pending state.
- Arithmetic: pc_mais4 = (pc + INCREMENTO) mod 2^LARGURA; wrap-around is silent.
- Next address (proximo), combinational:
  - 000: pc_mais4.
  - 001: endJump.
  - 010: zero=1 ? endDesvio : pc_mais4.
  - 011: zero=0 ? endDesvio : pc_mais4.
  - 100 (call): endJump; push pc_mais4.
  - 101 (return): if not empty, the top entry, then pop; if empty, endRegistrador and set erro_pilha.
  - 110: endRegistrador.
  - 111: reserved; pc_mais4, no stack action.
- desvio_tomado = 1 for 001, 100, 101 and 110, and for 010/011 when the condition holds; otherwise 0. It is evaluated even when habilita=0.
- Update, at a rising edge with reset=0 and habilita=1:
  - pc <= proximo (1-cycle latency: a target presented in cycle N appears on pc in cycle N+1).
  - The stack action is performed in the same edge.
- Stall: habilita=0 holds pc, stack contents, pointer, occupancy and flags unchanged.
- Stack: circular buffer with top pointer.
  - Push: the pointer advances modulo PROF_PILHA and the entry is written; occupancy += 1, saturating at PROF_PILHA.
  - Push when full: overwrites the oldest entry; occupancy stays PROF_PILHA; erro_pilha <= 1.
  - Pop: the top entry is read, the pointer retreats modulo PROF_PILHA, occupancy -= 1.
  - Pop when empty: no pointer or occupancy change; erro_pilha <= 1.
- erro_pilha clears only on reset.
- Push and pop never occur in the same cycle, because sel is a single code.

Test Plan:
- Reset and sequential run: assert reset 1 cycle with ENDERECO_RESET=0, then sel=000 for 3 cycles → pc 0, 4, 8, 12; desvio_tomado=0; pilha_vazia=1.
- Branches: at pc=0x10, sel=010, zero=1, endDesvio=0x40 → pc=0x40, desvio_tomado=1. Then sel=011, zero=1 → pc=0x44, desvio_tomado=0.
- Call and return: at pc=0x100, sel=100, endJump=0x200 → pc=0x200, stack top=0x104. Then sel=101 → pc=0x104, pilha_vazia=1, erro_pilha=0.
- Overflow: 5 calls from pc=0x0, 0x10, 0x20, 0x30, 0x40 (all endJump=0x1000) → pilha_cheia=1, erro_pilha=1. Then 4 returns yield 0x44, 0x34, 0x24, 0x14.
- Underflow and stall:
  - Empty stack, sel=101, endRegistrador=0x80 → pc=0x80, erro_pilha=1.
  - habilita=0 with sel=001, endJump=0x999 for 3 cycles → pc unchanged, desvio_tomado=1.
- Wrap and mid-operation reset:
  - LARGURA=8, pc=0xFC, sel=000 → pc=0x00.
  - Reset asserted after 2 calls → occupancy 0, erro_pilha=0, pc=ENDERECO_RESET next cycle.
